// File: rtl/sram_frame_reader.sv
// Avalon read master that streams a frame buffer from SRAM into a first-word
// fall-through pixel FIFO. Credit-based flow control keeps the FIFO from overflowing.
module sram_frame_reader #(
  parameter int          AVN_AW      = 19,
  parameter int          AVN_DW      = 16,
  parameter int unsigned BASE_ADDR   = 0,
  parameter int          FRAME_WORDS = 307200,
  parameter int          FIFO_DEPTH  = 16,
  parameter int          RD_LATENCY  = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              frame_start,
  input  logic              bus_grant,
  output logic              avn_read,
  output logic [AVN_AW-1:0] avn_address,
  input  logic [AVN_DW-1:0] avn_readdata,
  output logic              pix_valid,
  output logic [AVN_DW-1:0] pix_data,
  input  logic              pix_ready,
  output logic              frame_done,
  output logic              underflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH) + 1;
  localparam int CNT_W = $clog2(FRAME_WORDS + 1);
  localparam int INF_W = $clog2(RD_LATENCY + 1);
  localparam int BYTES = AVN_DW / 8;
  localparam logic [AVN_AW-1:0] BASE     = AVN_AW'(BASE_ADDR);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(FRAME_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      word_cnt_q;
  logic [RD_LATENCY-1:0] vld_q, vld_d;
  logic [RD_LATENCY-1:0] last_q, last_d;
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [PTR_W-1:0]      fifo_count;
  logic [INF_W-1:0]      inflight;
  logic [AVN_DW-1:0]     mem [FIFO_DEPTH];
  logic                  underflow_q, frame_done_q, last_written_q;

  logic fifo_empty, fifo_full, credit_ok;
  logic issue, last_issue, tail_vld, tail_last, push, pop;

  assign fifo_count = wr_ptr_q - rd_ptr_q;
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {(PTR_W-1){1'b0}}});

  // NOTE: blocking '=' is correct inside always_comb; it accumulates within one evaluation.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight = inflight + INF_W'(vld_q[i]);
    end
  end

  // Count in-flight returns as already occupying FIFO slots.
  assign credit_ok  = (32'(fifo_count) + 32'(inflight)) < 32'(FIFO_DEPTH);
  assign issue      = (state_q == FETCH) && bus_grant && credit_ok && !frame_start;
  assign last_issue = issue && (word_cnt_q == LAST_CNT);

  assign tail_vld  = vld_q[RD_LATENCY-1];
  assign tail_last = last_q[RD_LATENCY-1];
  assign push      = tail_vld && !fifo_full;
  assign pop       = pix_ready && pix_valid;

  // Latency tracker: each issued read walks toward the tail alongside its last-word tag.
  always_comb begin
    vld_d     = '0;
    last_d    = '0;
    vld_d[0]  = issue;
    last_d[0] = last_issue;
    for (int i = 1; i < RD_LATENCY; i++) begin
      vld_d[i]  = vld_q[i-1];
      last_d[i] = last_q[i-1];
    end
  end

  // NOTE: defaults first in always_comb so no path leaves state_d unassigned (no latch).
  always_comb begin
    state_d = state_q;
    if (frame_start) begin
      state_d = FETCH;
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        FETCH:   if (last_issue) state_d = DRAIN;
        DRAIN:   if ((inflight == '0) && last_written_q) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses '<=' so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      word_cnt_q     <= '0;
      vld_q          <= '0;
      last_q         <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      underflow_q    <= 1'b0;
      frame_done_q   <= 1'b0;
      last_written_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (frame_start) begin
        // Restart: flush FIFO, drop every in-flight return, clear sticky status.
        word_cnt_q     <= '0;
        vld_q          <= '0;
        last_q         <= '0;
        wr_ptr_q       <= '0;
        rd_ptr_q       <= '0;
        underflow_q    <= 1'b0;
        frame_done_q   <= 1'b0;
        last_written_q <= 1'b0;
      end else begin
        vld_q        <= vld_d;
        last_q       <= last_d;
        frame_done_q <= push && tail_last;
        if (issue)              word_cnt_q     <= word_cnt_q + 1'b1;
        if (push)               wr_ptr_q       <= wr_ptr_q + 1'b1;
        if (pop)                rd_ptr_q       <= rd_ptr_q + 1'b1;
        if (pix_ready && !pix_valid) underflow_q <= 1'b1;
        if (push && tail_last)  last_written_q <= 1'b1;
      end
    end
  end

  // NOTE: the storage array has no reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q[PTR_W-2:0]] <= avn_readdata;
  end

  assign avn_read    = issue;
  assign avn_address = BASE + AVN_AW'(32'(word_cnt_q) * BYTES);
  assign pix_valid   = !fifo_empty;
  assign pix_data    = pix_valid ? mem[rd_ptr_q[PTR_W-2:0]] : '0;
  assign frame_done  = frame_done_q;
  assign underflow   = underflow_q;

endmodule

// File: tb/tb_sram_frame_reader.sv
// Directed bench for sram_frame_reader: small frame, shallow FIFO, 1-cycle SRAM model
// returning the word index as data.
module tb_sram_frame_reader;

  localparam int AW = 19;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          frame_start = 1'b0;
  logic          bus_grant = 1'b0;
  logic          avn_read;
  logic [AW-1:0] avn_address;
  logic [DW-1:0] avn_readdata = '0;
  logic          pix_valid;
  logic [DW-1:0] pix_data;
  logic          pix_ready = 1'b0;
  logic          frame_done;
  logic          underflow;

  int n_checks = 0;
  int n_fail   = 0;

  sram_frame_reader #(
    .AVN_AW(AW), .AVN_DW(DW), .BASE_ADDR(0),
    .FRAME_WORDS(8), .FIFO_DEPTH(4), .RD_LATENCY(1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .frame_start(frame_start), .bus_grant(bus_grant),
    .avn_read(avn_read), .avn_address(avn_address), .avn_readdata(avn_readdata),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
    .frame_done(frame_done), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // SRAM model: data = word index, valid the cycle after the request.
  always @(posedge clk) begin
    avn_readdata <= avn_read ? DW'(avn_address >> 1) : 16'hBEEF;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle, drive inputs away from the edge, let combinational outputs settle.
  task automatic cyc(input logic fs, input logic gnt, input logic rdy);
    @(posedge clk);
    #2;
    frame_start = fs;
    bus_grant   = gnt;
    pix_ready   = rdy;
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " avn_read"},    32'(avn_read),    32'd0);
    check({tag, " avn_address"}, 32'(avn_address), 32'd0);
    check({tag, " pix_valid"},   32'(pix_valid),   32'd0);
    check({tag, " pix_data"},    32'(pix_data),    32'd0);
    check({tag, " frame_done"},  32'(frame_done),  32'd0);
    check({tag, " underflow"},   32'(underflow),   32'd0);
    check({tag, " fifo_count"},  32'(dut.fifo_count), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, and no reads while idle even with the bus granted.
    cyc(0, 1, 0);
    check_reset_outputs("reset");
    @(posedge clk); #2 reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc(0, 1, 0);
      check("idle no read", 32'(avn_read), 32'd0);
    end

    // 1: full frame, consumer keeps up. Reads in S+1..S+8, pixels k-3 in S+3..S+10.
    cyc(1, 1, 0);
    check("t1 no read in start cycle", 32'(avn_read), 32'd0);
    for (int k = 1; k <= 12; k++) begin
      cyc(0, 1, (k >= 3 && k <= 10));
      check("t1 avn_read", 32'(avn_read), 32'(k <= 8));
      if (k <= 8) check("t1 avn_address", 32'(avn_address), 32'(2 * (k - 1)));
      check("t1 pix_valid", 32'(pix_valid), 32'(k >= 3 && k <= 10));
      check("t1 pix_data", 32'(pix_data), (k >= 3 && k <= 10) ? 32'(k - 3) : 32'd0);
      check("t1 frame_done", 32'(frame_done), 32'(k == 10));
      check("t1 underflow", 32'(underflow), 32'd0);
    end

    // 2: stalled consumer, four credits then stop; release and drain the rest.
    cyc(1, 1, 0);
    for (int k = 1; k <= 7; k++) begin
      cyc(0, 1, 0);
      check("t2 avn_read", 32'(avn_read), 32'(k <= 4));
      if (k <= 4) check("t2 avn_address", 32'(avn_address), 32'(2 * (k - 1)));
      check("t2 pix_valid", 32'(pix_valid), 32'(k >= 3));
    end
    check("t2 fifo_count full", 32'(dut.fifo_count), 32'd4);
    check("t2 head", 32'(pix_data), 32'd0);
    for (int j = 0; j <= 8; j++) begin
      cyc(0, 1, (j <= 7));
      check("t2 drain avn_read", 32'(avn_read), 32'(j >= 1 && j <= 4));
      if (j >= 1 && j <= 4) check("t2 drain avn_address", 32'(avn_address), 32'(8 + 2 * (j - 1)));
      check("t2 drain pix_valid", 32'(pix_valid), 32'(j <= 7));
      if (j <= 7) check("t2 drain pix_data", 32'(pix_data), 32'(j));
      check("t2 frame_done", 32'(frame_done), 32'(j == 6));
      check("t2 underflow", 32'(underflow), 32'd0);
    end

    // 3: grant toggles 1,0,1,0,... reads only in granted cycles, addresses contiguous.
    cyc(1, 1, 0);
    for (int k = 1; k <= 6; k++) begin
      cyc(0, (k % 2 == 1), 0);
      check("t3 avn_read", 32'(avn_read), 32'(k % 2 == 1));
      check("t3 avn_address", 32'(avn_address), 32'(2 * (k / 2)));
    end
    cyc(0, 0, 0);
    check("t3 head", 32'(pix_data), 32'd0);
    check("t3 fifo_count", 32'(dut.fifo_count), 32'd3);

    // 4: restart mid-FETCH after five reads, word 4 still in flight.
    cyc(1, 1, 0);
    for (int k = 1; k <= 5; k++) begin
      cyc(0, 1, (k >= 3));
      check("t4 avn_read", 32'(avn_read), 32'd1);
      check("t4 avn_address", 32'(avn_address), 32'(2 * (k - 1)));
    end
    check("t4 pix_data before restart", 32'(pix_data), 32'd2);
    cyc(1, 1, 1);
    check("t4 no read in restart cycle", 32'(avn_read), 32'd0);
    check("t4 pix_data restart cycle", 32'(pix_data), 32'd3);
    cyc(0, 1, 0);
    check("t4 flushed pix_valid", 32'(pix_valid), 32'd0);
    check("t4 flushed pix_data", 32'(pix_data), 32'd0);
    check("t4 flushed fifo_count", 32'(dut.fifo_count), 32'd0);
    check("t4 restart avn_read", 32'(avn_read), 32'd1);
    check("t4 restart avn_address", 32'(avn_address), 32'd0);
    cyc(0, 1, 0);
    check("t4 dropped word not written", 32'(pix_valid), 32'd0);
    check("t4 second address", 32'(avn_address), 32'd2);
    cyc(0, 1, 0);
    check("t4 first pixel valid", 32'(pix_valid), 32'd1);
    check("t4 first pixel data", 32'(pix_data), 32'd0);

    // 5: pop with empty FIFO sets sticky underflow; only frame_start clears it.
    cyc(1, 1, 0);
    cyc(0, 1, 1);
    check("t5 empty at pulse", 32'(pix_valid), 32'd0);
    check("t5 underflow before", 32'(underflow), 32'd0);
    cyc(0, 1, 0);
    check("t5 underflow set", 32'(underflow), 32'd1);
    check("t5 no spurious pixel", 32'(pix_valid), 32'd0);
    for (int k = 3; k <= 6; k++) begin
      cyc(0, 1, 0);
      check("t5 underflow sticky", 32'(underflow), 32'd1);
      if (k == 3) check("t5 pixel unaffected", 32'(pix_data), 32'd0);
    end
    cyc(1, 1, 0);
    check("t5 underflow until edge", 32'(underflow), 32'd1);
    cyc(0, 1, 1);
    check("t5 underflow cleared", 32'(underflow), 32'd0);
    check("t5 read after clear", 32'(avn_read), 32'd1);

    // 6: asynchronous reset mid-FETCH with live state.
    cyc(0, 1, 0);
    check("t6 underflow pre-reset", 32'(underflow), 32'd1);
    cyc(0, 1, 0);
    check("t6 pix_valid pre-reset", 32'(pix_valid), 32'd1);
    check("t6 avn_read pre-reset", 32'(avn_read), 32'd1);
    check("t6 avn_address pre-reset", 32'(avn_address), 32'd4);
    #1 reset_n = 1'b0;
    #1;
    check_reset_outputs("t6 async");
    @(posedge clk); #2 reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc(0, 1, 0);
      check("t6 no read after reset", 32'(avn_read), 32'd0);
    end
    cyc(1, 1, 0);
    cyc(0, 1, 0);
    check("t6 read after frame_start", 32'(avn_read), 32'd1);
    check("t6 address after frame_start", 32'(avn_address), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
